// File: rtl/robot_cmd_pkg.sv
// robot_cmd_pkg: shared types, IR key codes, JSON frame template and byte/decode helpers
package robot_cmd_pkg;
  typedef enum logic [2:0] {NONE, FWD, BWD, LEFT, RIGHT, STOP} cmd_e;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;
  typedef struct packed {
    cmd_e       cmd;
    logic [7:0] digit;
  } entry_t;
  localparam logic [15:0] KEY_FWD   = 16'hEC13;
  localparam logic [15:0] KEY_BWD   = 16'hFD02;
  localparam logic [15:0] KEY_LEFT  = 16'hF00F;
  localparam logic [15:0] KEY_RIGHT = 16'hEF10;
  localparam logic [15:0] KEY_STOP  = 16'hFA05;
  localparam int JSON_LEN = 24;
  // speed fields (bytes 11..13 and 19..21) are placeholders, filled in by frame_byte
  localparam logic [8*JSON_LEN-1:0] TEMPLATE = "{\"T\":1,\"L\":000,\"R\":000}\n";

  // key code lives in the upper half of the receiver word
  function automatic cmd_e decode(logic [31:0] word);
    return word[31:16] == KEY_FWD   ? FWD   :
           word[31:16] == KEY_BWD   ? BWD   :
           word[31:16] == KEY_LEFT  ? LEFT  :
           word[31:16] == KEY_RIGHT ? RIGHT :
           word[31:16] == KEY_STOP  ? STOP  : NONE;
  endfunction

  function automatic logic [7:0] frame_byte(cmd_e cmd, logic [7:0] digit, logic [4:0] idx);
    int  i;
    int  o;
    logic neg;
    i   = int'(idx);
    o   = i < 16 ? i - 11 : i - 19;
    neg = i < 16 ? (cmd == BWD || cmd == LEFT) : (cmd == BWD || cmd == RIGHT);
    if ((i >= 11 && i <= 13) || (i >= 19 && i <= 21))
      return o == 0 ? (neg ? "-" : "0") : o == 1 ? "." : (cmd == STOP ? "0" : digit);
    return TEMPLATE[8*(JSON_LEN-1-i) +: 8];
  endfunction
endpackage

// File: rtl/robot_cmd_sequencer_fifo.sv
// robot_cmd_fifo: command queue with push, pop and a single-cycle flush_and_push
//   push/pop: normal enqueue/dequeue, ignored when full/empty
//   flush_and_push: discard all entries and leave din as the only one (wins over pop)
//   head: current head entry; level/full/empty: occupancy
module robot_cmd_fifo
  import robot_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush_and_push,
  input  entry_t        din,
  output entry_t        head,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic push_ok, pop_ok;
  assign full    = level == LW'(DEPTH);
  assign empty   = level == '0;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd];
  always_ff @(posedge clk)
    if (flush_and_push || push_ok) mem[flush_and_push ? '0 : wr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd    <= '0;
      wr    <= '0;
      level <= '0;
    end else if (flush_and_push) begin
      rd    <= '0;
      wr    <= AW'(1);
      level <= LW'(1);
    end else begin
      if (push_ok) wr <= wr + 1'b1;
      if (pop_ok) rd <= rd + 1'b1;
      level <= level + LW'(push_ok) - LW'(pop_ok);
    end
endmodule

// File: rtl/robot_cmd_sequencer.sv
// robot_cmd_sequencer: IR key codes -> queued drive commands -> 24-byte JSON lines over a byte handshake
//   ir_valid/ir_code: receiver level and word (key in [31:16]); tx_data/tx_valid/tx_ready: byte stream
//   busy: frame in progress; fifo_level: queued commands; drop_count: saturating overflow count
//   ROBOT_CMD_SPEED_SEL_EN: adds speed_sel[1:0] choosing the speed digit ('1','3','5','9')
module robot_cmd_sequencer
  import robot_cmd_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int HOLDOFF_MS = 150,
  parameter int FIFO_DEPTH = 4,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ir_valid,
  input  logic [31:0]   ir_code,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          busy,
  output logic [LW-1:0] fifo_level,
  output logic [7:0]    drop_count
`ifdef ROBOT_CMD_SPEED_SEL_EN
  ,
  input  logic [1:0]    speed_sel
`endif
);
  localparam longint HOLD = longint'(HOLDOFF_MS) * longint'(CLK_HZ) / 1000;
  localparam int TW = $clog2(HOLD + 2);
  logic ir_q, ev, accept, full, empty, pop, push, flush;
  logic [TW-1:0] timer;
  logic [7:0] digit;
  logic [4:0] idx;
  cmd_e cmd, last_cmd;
  entry_t head, cur;
  state_e state;
`ifdef ROBOT_CMD_SPEED_SEL_EN
  assign digit = speed_sel == 2'd0 ? "1" : speed_sel == 2'd1 ? "3" : speed_sel == 2'd2 ? "5" : "9";
`else
  assign digit = "1";
`endif
  assign ev     = ir_valid && !ir_q;
  assign cmd    = decode(ir_code);
  // a repeat of the last accepted command is swallowed while the holdoff runs
  assign accept = ev && cmd != NONE && !(cmd == last_cmd && timer != '0);
  assign flush  = accept && cmd == STOP;
  assign push   = accept && cmd != STOP && !full;
  assign pop    = state == IDLE && !empty;

  robot_cmd_fifo #(.DEPTH(FIFO_DEPTH), .LW(LW)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush_and_push(flush),
    .din('{cmd: cmd, digit: digit}), .head(head), .level(fifo_level), .full(full), .empty(empty)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ir_q       <= 1'b0;
      timer      <= '0;
      last_cmd   <= NONE;
      drop_count <= '0;
    end else begin
      ir_q <= ir_valid;
      if (accept) begin
        timer    <= TW'(HOLD);
        last_cmd <= cmd;
      end else if (timer != '0) timer <= timer - 1'b1;
      if (accept && cmd != STOP && full && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      cur      <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
    end else
      case (state)
        IDLE: if (!empty) begin
          cur      <= head;
          idx      <= '0;
          tx_data  <= frame_byte(head.cmd, head.digit, 5'd0);
          tx_valid <= 1'b1;
          busy     <= 1'b1;
          state    <= SEND;
        end
        SEND: if (tx_ready) begin
          if (idx == 5'(JSON_LEN - 1)) begin
            tx_valid <= 1'b0;
            state    <= GAP;
          end else begin
            idx     <= idx + 1'b1;
            tx_data <= frame_byte(cur.cmd, cur.digit, idx + 1'b1);
          end
        end
        GAP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_robot_cmd_sequencer.sv
// tb_robot_cmd_sequencer: directed + random presses checked against a queue-based reference model
module tb_robot_cmd_sequencer;
  localparam int CLK_HZ = 20_000;
  localparam int HOLDOFF_MS = 150;
  localparam int DEPTH = 4;
  localparam int HOLD = HOLDOFF_MS * CLK_HZ / 1000;
  localparam int MS = CLK_HZ / 1000;

  logic clk = 0, rst = 1, ir_valid = 0, tx_ready = 0, tx_valid, busy;
  logic [31:0] ir_code = 0;
  logic [7:0] tx_data, drop_count;
  logic [$clog2(DEPTH):0] fifo_level;
`ifdef ROBOT_CMD_SPEED_SEL_EN
  logic [1:0] speed_sel = 0;
`endif

  robot_cmd_sequencer #(.CLK_HZ(CLK_HZ), .HOLDOFF_MS(HOLDOFF_MS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ir_valid(ir_valid), .ir_code(ir_code), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .fifo_level(fifo_level),
    .drop_count(drop_count)
`ifdef ROBOT_CMD_SPEED_SEL_EN
    , .speed_sel(speed_sel)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  task automatic chk(string n, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", n, act, act, exp, exp, $time);
    end
  endtask

  // reference model: commands are 1 FWD, 2 BWD, 3 LEFT, 4 RIGHT, 5 STOP; entry = cmd*256 + digit
  int mq[$];
  logic [7:0] exp_q[$];
  int m_phase = 0, m_rem = 0, m_drop = 0, m_last = 0, m_acc = -100000, cyc = 0;
  bit m_irq = 0;

  function automatic int mdec(logic [15:0] k);
    case (k)
      16'hEC13: return 1;
      16'hFD02: return 2;
      16'hF00F: return 3;
      16'hEF10: return 4;
      16'hFA05: return 5;
      default:  return 0;
    endcase
  endfunction

  function automatic logic [7:0] mdig();
`ifdef ROBOT_CMD_SPEED_SEL_EN
    case (speed_sel)
      2'd0: return "1";
      2'd1: return "3";
      2'd2: return "5";
      default: return "9";
    endcase
`else
    return "1";
`endif
  endfunction

  function automatic string sp(int c, bit neg, logic [7:0] d);
    return $sformatf("%c.%c", neg ? 8'h2D : 8'h30, c == 5 ? 8'h30 : d);
  endfunction

  task automatic push_frame(int e);
    int c;
    string s;
    c = e / 256;
    s = $sformatf("{\"T\":1,\"L\":%s,\"R\":%s}\n", sp(c, c == 2 || c == 3, 8'(e % 256)),
                  sp(c, c == 2 || c == 4, 8'(e % 256)));
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  always @(posedge clk) begin
    int sz, c;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_phase = 0;
      m_rem = 0;
      m_drop = 0;
      m_last = 0;
      m_acc = -100000;
      m_irq = 0;
    end else begin
      sz = mq.size();
      if (m_phase == 0) begin
        if (sz > 0) begin
          push_frame(mq.pop_front());
          m_phase = 1;
          m_rem = 24;
        end
      end else if (m_phase == 1) begin
        if (tx_ready) begin
          m_rem--;
          if (m_rem == 0) m_phase = 2;
        end
      end else m_phase = 0;
      if (ir_valid && !m_irq) begin
        c = mdec(ir_code[31:16]);
        if (c != 0 && !(c == m_last && cyc - m_acc <= HOLD)) begin
          m_last = c;
          m_acc = cyc;
          if (c == 5) begin
            mq.delete();
            mq.push_back(5 * 256 + int'(mdig()));
          end else if (sz == DEPTH) m_drop = m_drop < 255 ? m_drop + 1 : 255;
          else mq.push_back(c * 256 + int'(mdig()));
        end
      end
      m_irq = ir_valid;
    end
    cyc++;
  end

  // monitor: compares every presented byte and the per-cycle status against the model
  bit hold_prev = 0;
  logic [7:0] prev_data = 0;
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      chk("tx_valid", int'(tx_valid), int'(m_phase == 1));
      chk("busy", int'(busy), int'(m_phase != 0));
      chk("fifo_level", int'(fifo_level), mq.size());
      chk("drop_count", int'(drop_count), m_drop);
      if (tx_valid && hold_prev) chk("tx_data_stable", int'(tx_data), int'(prev_data));
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) chk("unexpected_byte", int'(tx_data), -1);
        else chk("tx_byte", int'(tx_data), int'(exp_q.pop_front()));
      end
      hold_prev = tx_valid && !tx_ready;
      prev_data = tx_data;
    end else hold_prev = 0;
  end

  bit rand_rdy = 0;
  always @(negedge clk) if (rand_rdy) tx_ready = 1'($urandom_range(0, 1));

  task automatic press(logic [15:0] k, int hold, int gap);
    ir_code = {k, 16'(~k)};
    ir_valid = 1;
    repeat (hold) @(negedge clk);
    ir_valid = 0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (!(m_phase == 0 && mq.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("idle_timeout", n, -1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_idx(int idx, int budget);
    int n = 0;
    while (!(m_phase == 1 && 24 - m_rem == idx) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("idx_timeout", n, -1);
  endtask

  logic [15:0] keys [7] = '{16'hEC13, 16'hFD02, 16'hF00F, 16'hEF10, 16'hFA05, 16'h1234, 16'hEC14};

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_tx_valid", int'(tx_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_drops", int'(drop_count), 0);
    @(negedge clk);
    rst = 0;
    tx_ready = 1;
    repeat (2) @(negedge clk);
    // single FWD frame
    press(16'hEC13, 3, 2);
    wait_idle(200);
    // LEFT repeated after 1 ms is swallowed, again after 200 ms is sent
    press(16'hF00F, 2, MS);
    press(16'hF00F, 2, 3);
    chk("holdoff_level", int'(fifo_level), 0);
    wait_idle(200);
    chk("holdoff_drops", int'(drop_count), 0);
    repeat (200 * MS) @(negedge clk);
    press(16'hF00F, 2, 2);
    wait_idle(200);
    // stalled sink: one in SEND, four queued, sixth dropped
    tx_ready = 0;
    press(16'hEC13, 1, 3);
    press(16'hFD02, 1, 3);
    press(16'hF00F, 1, 3);
    press(16'hEF10, 1, 3);
    press(16'hEC13, 1, 3);
    press(16'hFD02, 1, 3);
    #2;
    chk("full_level", int'(fifo_level), 4);
    chk("full_drops", int'(drop_count), 1);
    chk("stall_byte", int'(tx_data), 8'h7B);
    tx_ready = 1;
    wait_idle(1000);
    // STOP mid-frame flushes the queue behind the current frame
    press(16'hEC13, 1, 1);
    press(16'hFD02, 1, 1);
    press(16'hF00F, 1, 1);
    press(16'hEF10, 1, 1);
    wait_idx(10, 100);
    ir_code = {16'hFA05, 16'h05FA};
    ir_valid = 1;
    @(negedge clk);
    #2;
    chk("stop_level", int'(fifo_level), 1);
    ir_valid = 0;
    wait_idle(300);
    // asynchronous reset mid-frame
    press(16'hFD02, 1, 1);
    wait_idx(12, 100);
    rst = 1;
    #1;
    chk("arst_tx_valid", int'(tx_valid), 0);
    chk("arst_tx_data", int'(tx_data), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_drops", int'(drop_count), 0);
    chk("arst_level", int'(fifo_level), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    press(16'hEC13, 1, 1);
    wait_idle(200);
`ifdef ROBOT_CMD_SPEED_SEL_EN
    speed_sel = 2'd2;
    press(16'hFD02, 1, 1);
    wait_idle(200);
`endif
    // random keys, random sink backpressure
    rand_rdy = 1;
    for (int i = 0; i < 150; i++) begin
`ifdef ROBOT_CMD_SPEED_SEL_EN
      speed_sel = 2'($urandom_range(0, 3));
`endif
      press(keys[$urandom_range(0, 6)], $urandom_range(1, 3), $urandom_range(1, 40));
    end
    rand_rdy = 0;
    @(negedge clk);
    tx_ready = 1;
    wait_idle(3000);
    chk("leftover_bytes", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
